// File: rtl/ucrv32_lsu_if.sv
// ucrv32_lsu_if: core request/response and single-port RAM signals of the LSU
interface ucrv32_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_err_o;
    logic                  mem_en_o;
    logic [3:0]            mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_WIDTH-1:0] mem_data_i;
    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_data_o
    );
    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/ucrv32_lsu.sv
// ucrv32_lsu: RV32I load/store unit driving one single-port RAM with 1-cycle read latency
module ucrv32_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic         clk_i,
    input logic         rst_ni,
    ucrv32_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t                state;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [1:0]            r_a;
    logic [2:0]            f3;
    logic [1:0]            a;
    logic                  illegal;
    logic [3:0]            st_we;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    assign f3 = bus.req_funct3_i;
    assign a  = bus.req_addr_i[1:0];
    assign ld_byte = bus.mem_data_i[8*r_a +: 8];
    assign ld_half = bus.mem_data_i[16*r_a[1] +: 16];
    always_comb begin
        illegal = f3 == 3'd3 || f3[2:1] == 2'b11 || (bus.req_we_i && f3 > 3'd2) ||
                  (f3[1:0] == 2'd1 && a[0]) || (f3 == 3'd2 && a != 2'd0);
        st_we   = f3[1:0] == 2'd0 ? 4'b0001 << a :
                  f3[1:0] == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data = f3[1:0] == 2'd0 ? {4{bus.req_wdata_i[7:0]}} :
                  f3[1:0] == 2'd1 ? {2{bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
        ld_data = r_f3 == 3'd0 ? {{24{ld_byte[7]}}, ld_byte} :
                  r_f3 == 3'd1 ? {{16{ld_half[15]}}, ld_half} :
                  r_f3 == 3'd4 ? {24'd0, ld_byte} :
                  r_f3 == 3'd5 ? {16'd0, ld_half} : bus.mem_data_i;
    end
    // RAM-side outputs are loaded at acceptance so they are valid throughout ISSUE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            r_we             <= 1'b0;
            r_f3             <= 3'd0;
            r_a              <= 2'd0;
            bus.req_ready_o  <= 1'b1;
            bus.resp_valid_o <= 1'b0;
            bus.resp_err_o   <= 1'b0;
            bus.resp_rdata_o <= '0;
            bus.mem_en_o     <= 1'b0;
            bus.mem_we_o     <= 4'd0;
            bus.mem_addr_o   <= '0;
            bus.mem_data_o   <= '0;
        end else begin
            bus.resp_valid_o <= 1'b0;
            bus.mem_en_o     <= 1'b0;
            bus.mem_we_o     <= 4'd0;
            case (state)
                IDLE: if (bus.req_valid_i) begin
                    r_we             <= bus.req_we_i;
                    r_f3             <= f3;
                    r_a              <= a;
                    bus.req_ready_o  <= 1'b0;
                    bus.resp_err_o   <= illegal;
                    bus.resp_rdata_o <= '0;
                    if (illegal) begin
                        state            <= RESP;
                        bus.resp_valid_o <= 1'b1;
                    end else begin
                        state          <= ISSUE;
                        bus.mem_en_o   <= 1'b1;
                        bus.mem_we_o   <= bus.req_we_i ? st_we : 4'd0;
                        bus.mem_addr_o <= {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        if (bus.req_we_i) bus.mem_data_o <= st_data;
                    end
                end
                ISSUE: begin
                    state            <= r_we ? RESP : WAIT;
                    bus.resp_valid_o <= r_we;
                end
                WAIT: begin
                    state            <= RESP;
                    bus.resp_valid_o <= 1'b1;
                    bus.resp_rdata_o <= ld_data;
                end
                RESP: begin
                    state           <= IDLE;
                    bus.req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ucrv32_lsu.sv
// tb_ucrv32_lsu: vector, directed and randomized checks of ucrv32_lsu against a behavioural model
module tb_ucrv32_lsu;
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic        err;
        int          lat;
        logic [3:0]  mwe;
        logic [31:0] mdata;
        logic [31:0] rdata;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_data = 32'd0;
    ucrv32_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();
    ucrv32_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bd_we) ram[bd_idx] <= bd_data;
        else if (bus.mem_en_o) begin
            for (int j = 0; j < 4; j++)
                if (bus.mem_we_o[j]) ram[bus.mem_addr_o[7:2]][8*j +: 8] <= bus.mem_data_o[8*j +: 8];
            bus.mem_data_i <= ram[bus.mem_addr_o[7:2]];
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, summary: %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic int size_of(input logic [2:0] f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction
    function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        return f3 == 3 || f3 >= 6 || (we && f3 > 2) || (addr % size_of(f3) != 0);
    endfunction
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] w = ref_mem[addr[7:2]];
        int sz = size_of(f3);
        longint v;
        if (sz == 4) return w;
        v = longint'((w >> (8 * (addr % 4))) & (sz == 1 ? 32'hFF : 32'hFFFF));
        if (f3 < 4 && v >= (sz == 1 ? 128 : 32768)) v -= (sz == 1 ? 256 : 65536);
        return v[31:0];
    endfunction
    task automatic ref_write(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int off = int'(addr % 4);
        if (we && !is_illegal(we, f3, addr))
            for (int i = 0; i < size_of(f3); i++) ref_mem[addr[7:2]][8*(off+i) +: 8] = wd[8*i +: 8];
    endtask
    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          output logic rdy, output int lat, output int vcnt, output int ecnt, output logic e1,
                          output logic [3:0] mwe, output logic [31:0] maddr, output logic [31:0] mdata,
                          output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_funct3_i = f3;
        bus.req_addr_i = addr; bus.req_wdata_i = wd;
        rdy = bus.req_ready_o;
        lat = 0; vcnt = 0; ecnt = 0; e1 = 1'b0; mwe = 4'd0; maddr = 0; mdata = 0; rdata = 0; err = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.req_valid_i = 1'b0;
                e1 = bus.mem_en_o;
            end
            if (bus.mem_en_o) begin
                ecnt++;
                mwe = bus.mem_we_o; maddr = bus.mem_addr_o; mdata = bus.mem_data_o;
            end
            if (bus.resp_valid_o) begin
                vcnt++;
                if (lat == 0) begin
                    lat = k; rdata = bus.resp_rdata_o; err = bus.resp_err_o;
                end
            end
        end
    endtask
    initial begin
        vec_t        v[14];
        logic        rdy, e1, err, we, bad;
        int          lat, vcnt, ecnt;
        logic [3:0]  mwe, em;
        logic [31:0] maddr, mdata, rdata, addr, wd, exp_r, ed;
        logic [2:0]  f3;
        v[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'hF, 32'hDEADBEEF, 32'h0};
        v[1]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1'b0, 2, 4'h8, 32'hA5A5A5A5, 32'h0};
        v[2]  = '{1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1'b0, 2, 4'hC, 32'h12341234, 32'h0};
        v[3]  = '{1'b0, 3'd0, 32'h101, 32'h0, 32'h80FF7F01, 1'b0, 3, 4'h0, 32'h0, 32'h0000007F};
        v[4]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 1'b0, 3, 4'h0, 32'h0, 32'hFFFFFF80};
        v[5]  = '{1'b0, 3'd4, 32'h102, 32'h0, 32'h80FF7F01, 1'b0, 3, 4'h0, 32'h0, 32'h000000FF};
        v[6]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF7F01, 1'b0, 3, 4'h0, 32'h0, 32'hFFFF80FF};
        v[7]  = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF7F01, 1'b0, 3, 4'h0, 32'h0, 32'h000080FF};
        v[8]  = '{1'b0, 3'd2, 32'h102, 32'h0, 32'h11111111, 1'b1, 1, 4'h0, 32'h0, 32'h0};
        v[9]  = '{1'b1, 3'd1, 32'h101, 32'hBEEF, 32'h0, 1'b1, 1, 4'h0, 32'h0, 32'h0};
        v[10] = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h22222222, 1'b1, 1, 4'h0, 32'h0, 32'h0};
        v[11] = '{1'b1, 3'd4, 32'h100, 32'h55, 32'h0, 1'b1, 1, 4'h0, 32'h0, 32'h0};
        v[12] = '{1'b0, 3'd6, 32'h100, 32'h0, 32'h33333333, 1'b1, 1, 4'h0, 32'h0, 32'h0};
        v[13] = '{1'b0, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 1'b0, 3, 4'h0, 32'h0, 32'h13579BDF};
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'd0;
        bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready", bus.req_ready_o, 1);
        chk("reset_valid", bus.resp_valid_o, 0);
        chk("reset_en", bus.mem_en_o, 0);
        chk("reset_addr", bus.mem_addr_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        foreach (v[i]) begin
            preload(v[i].addr[7:2], v[i].pre);
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rdy, lat, vcnt, ecnt, e1, mwe, maddr, mdata, rdata, err);
            ref_write(v[i].we, v[i].f3, v[i].addr, v[i].wdata);
            chk($sformatf("vec%0d_ready", i), rdy, 1);
            chk($sformatf("vec%0d_latency", i), lat, v[i].lat);
            chk($sformatf("vec%0d_resp_count", i), vcnt, 1);
            chk($sformatf("vec%0d_err", i), err, v[i].err);
            chk($sformatf("vec%0d_rdata", i), rdata, v[i].rdata);
            chk($sformatf("vec%0d_en_count", i), ecnt, v[i].err ? 0 : 1);
            if (!v[i].err) begin
                chk($sformatf("vec%0d_en_at_n1", i), e1, 1);
                chk($sformatf("vec%0d_mem_addr", i), maddr, v[i].addr & 32'hFFFF_FFFC);
                chk($sformatf("vec%0d_mem_we", i), mwe, v[i].mwe);
            end
            if (v[i].we && !v[i].err) chk($sformatf("vec%0d_mem_data", i), mdata, v[i].mdata);
        end
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 255);
            wd = $urandom;
            bad = is_illegal(we, f3, addr);
            exp_r = (we || bad) ? 32'd0 : exp_load(f3, addr);
            em = 4'd0;
            ed = 32'd0;
            if (we && !bad) begin
                for (int i = 0; i < size_of(f3); i++) em[addr % 4 + i] = 1'b1;
                for (int j = 0; j < 4; j++) ed[8*j +: 8] = wd[8*(j % size_of(f3)) +: 8];
            end
            do_req(we, f3, addr, wd, rdy, lat, vcnt, ecnt, e1, mwe, maddr, mdata, rdata, err);
            ref_write(we, f3, addr, wd);
            chk($sformatf("rnd%0d_latency", n), lat, bad ? 1 : we ? 2 : 3);
            chk($sformatf("rnd%0d_err", n), err, bad);
            chk($sformatf("rnd%0d_rdata", n), rdata, exp_r);
            chk($sformatf("rnd%0d_en_count", n), ecnt, bad ? 0 : 1);
            if (!bad) begin
                chk($sformatf("rnd%0d_mem_addr", n), maddr, addr & 32'hFFFF_FFFC);
                chk($sformatf("rnd%0d_mem_we", n), mwe, em);
                if (we) chk($sformatf("rnd%0d_mem_data", n), mdata, ed);
            end
        end
        exp_r = exp_load(3'd2, 32'h104);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'd2; bus.req_addr_i = 32'h104;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk($sformatf("b2b%0d_ready", k), bus.req_ready_o, k % 4 == 0);
            chk($sformatf("b2b%0d_valid", k), bus.resp_valid_o, k % 4 == 3);
            if (k % 4 == 3) chk($sformatf("b2b%0d_rdata", k), bus.resp_rdata_o, exp_r);
            @(posedge clk);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'd2; bus.req_addr_i = 32'h104;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", bus.req_ready_o, 1);
        chk("rst_valid", bus.resp_valid_o, 0);
        chk("rst_err", bus.resp_err_o, 0);
        chk("rst_rdata", bus.resp_rdata_o, 0);
        chk("rst_en", bus.mem_en_o, 0);
        chk("rst_we", bus.mem_we_o, 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_data", bus.mem_data_o, 0);
        vcnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1 vcnt += int'(bus.resp_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1 vcnt += int'(bus.resp_valid_o);
        end
        chk("rst_no_resp", vcnt, 0);
        do_req(1'b0, 3'd2, 32'h104, 32'd0, rdy, lat, vcnt, ecnt, e1, mwe, maddr, mdata, rdata, err);
        chk("post_rst_ready", rdy, 1);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", rdata, exp_r);
        chk("post_rst_err", err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ucrv32_lsu.md
UCRV32_LSU -- requirements
Module: ucrv32_lsu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid_i, input, 1, meaning a core request is present.
REQ-006 The block SHALL have port req_ready_o, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have port req_we_i, input, 1, meaning 1=store and 0=load.
REQ-008 The block SHALL have port req_funct3_i, input, 3, meaning the RV32I size code (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
REQ-009 The block SHALL have port req_addr_i, input, ADDR_WIDTH, meaning the byte address.
REQ-010 The block SHALL have port req_wdata_i, input, DATA_WIDTH, meaning store data, right-aligned.
REQ-011 The block SHALL have port resp_valid_o, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata_o, output, DATA_WIDTH, meaning extended load data (0 for stores and errors).
REQ-013 The block SHALL have port resp_err_o, output, 1, meaning misaligned or illegal request; qualified by resp_valid_o.
REQ-014 The block SHALL have ports mem_en_o (output, 1), mem_we_o (output, 4, byte enables), mem_addr_o (output, ADDR_WIDTH, word-aligned byte address), mem_data_o (output, DATA_WIDTH) and mem_data_i (input, DATA_WIDTH), which drive the master side of one RAM port with 1-cycle synchronous read latency.

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid_i and req_ready_o are both 1, and all req_* inputs are registered at that edge.
REQ-017 On acceptance the FSM SHALL go to ISSUE if legal, else directly to RESP with the error flag set.
REQ-018 A request SHALL be illegal when funct3 is 3, 6 or 7; or on a store with funct3 > 2; or on a halfword with addr[0]=1; or on a word with addr[1:0] != 0.
REQ-019 In ISSUE the block SHALL drive mem_en_o=1 and mem_addr_o={addr[ADDR_WIDTH-1:2],2'b00}; a store then goes to RESP and a load goes to WAIT.
REQ-020 In ISSUE for a store, mem_we_o SHALL be SB: 4'b0001<<addr[1:0]; SH: 4'b0011 if addr[1]=0, else 4'b1100; SW: 4'b1111.
REQ-021 In ISSUE for a store, mem_data_o SHALL be the byte replicated x4 (SB), the halfword replicated x2 (SH), or the full word (SW).
REQ-022 In ISSUE for a load, mem_we_o SHALL be 0.
REQ-023 Outside ISSUE, mem_en_o and mem_we_o SHALL be 0; mem_addr_o and mem_data_o hold their last values.
REQ-024 In WAIT the block SHALL select a lane from mem_data_i: byte = bits [8*addr[1:0]+:8], half = bits [16*addr[1]+:16].
REQ-025 In WAIT the block SHALL sign-extend for funct3 0/1, zero-extend for 4/5, pass 2 through, register the result into resp_rdata_o, and go to RESP.
REQ-026 In RESP the block SHALL assert resp_valid_o for exactly one cycle and return to IDLE; there is no response backpressure.
REQ-027 Latency from the acceptance edge N SHALL be: error response at cycle N+1, store response at N+2, load response at N+3.
REQ-028 The next request SHALL be acceptable in the cycle after RESP; req_valid_i held while busy SHALL be ignored and not queued.
REQ-029 For stores and errors resp_rdata_o SHALL be 0, and resp_err_o SHALL be 0 on all successful responses.

Reset
REQ-030 Asserting rst_ni low SHALL immediately, without waiting for a clock, force state IDLE and req_ready_o=1.
REQ-031 Reset SHALL immediately force resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0 and mem_data_o=0.
REQ-032 A reset in ISSUE or WAIT SHALL abort the access with no response; the first request after release behaves as if from power-up.

Verification
REQ-033 SW addr 0x100 data 0xDEADBEEF -> at N+1 mem_en_o=1, mem_we_o=4'b1111, mem_addr_o=0x100, mem_data_o=0xDEADBEEF; resp_valid_o=1 at N+2 with resp_err_o=0.
REQ-034 SB addr 0x103 data 0x000000A5 -> mem_we_o=4'b1000, mem_data_o=0xA5A5A5A5; SH addr 0x102 data 0x1234 -> mem_we_o=4'b1100, mem_data_o=0x12341234.
REQ-035 mem_data_i=0x80FF7F01 at WAIT -> LB addr 1 yields 0x0000007F; LB addr 3 yields 0xFFFFFF80; LBU addr 2 yields 0x000000FF; LH addr 2 yields 0xFFFF80FF; LHU addr 2 yields 0x000080FF; each at N+3.
REQ-036 LW addr 0x102, SH addr 0x101 and funct3=3 -> no mem_en_o pulse; resp_valid_o=1 and resp_err_o=1 at N+1.
REQ-037 Back-to-back req_valid_i held high -> accepted only in IDLE, giving one load every 4 cycles; req_ready_o=0 during ISSUE, WAIT and RESP.
REQ-038 rst_ni pulsed low during WAIT -> outputs zero immediately, no resp_valid_o pulse; the following LW completes normally at N+3.
